// File: rtl/mem_stage_sized.sv
// Sized data-memory stage: byte/half/word loads and stores with extension,
// registered read, fault detection, sticky error and saturating counters.
module mem_stage_sized #(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 32,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] alu_result,
   input  logic [31:0]       read_data2,
   input  logic              memwrite,
   input  logic              memread,
   input  logic [1:0]        mem_size,
   input  logic              mem_unsigned,
   output logic [31:0]       read_data_out,
   output logic              read_valid,
   output logic              fault,
   output logic              err_sticky,
   output logic [CNT_W-1:0]  load_count,
   output logic [CNT_W-1:0]  store_count
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   logic [31:0]      mem [DEPTH_WORDS];

   logic [IDX_W-1:0] idx;
   logic [1:0]       lane;
   logic             in_range;
   logic             aligned;
   logic             legal;
   logic             req;
   logic             conflict;
   logic             do_store;
   logic             do_load;
   logic [3:0]       be;
   logic [31:0]      wdata;
   logic [31:0]      rd_word;
   logic [7:0]       rd_byte;
   logic [15:0]      rd_half;
   logic [31:0]      ld_ext;

   assign idx  = alu_result[IDX_W+1:2];
   assign lane = alu_result[1:0];

   // Address checks: range, alignment and size legality.
   always_comb begin
      in_range = ((alu_result >> (IDX_W + 2)) == '0);
      aligned  = 1'b0;
      case (mem_size)
         SZ_WORD: aligned = (lane == 2'b00);
         SZ_HALF: aligned = ~lane[0];
         SZ_BYTE: aligned = 1'b1;
         default: aligned = 1'b0;
      endcase
      legal    = in_range & aligned;
      req      = memwrite | memread;
      conflict = memwrite & memread;
      do_store = ~rst & memwrite & legal;
      do_load  = ~rst & memread & ~memwrite & legal;
   end

   // Lane enables and replicated store data for sub-word writes.
   always_comb begin
      be    = 4'b0000;
      wdata = read_data2;
      case (mem_size)
         SZ_WORD: be = 4'b1111;
         SZ_HALF: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{read_data2[15:0]}};
         end
         SZ_BYTE: begin
            be    = 4'b0001 << lane;
            wdata = {4{read_data2[7:0]}};
         end
         default: be = 4'b0000;
      endcase
   end

   // Load lane select and sign/zero extension.
   always_comb begin
      rd_word = mem[idx];
      rd_byte = rd_word[{lane, 3'b000} +: 8];
      rd_half = rd_word[{lane[1], 4'b0000} +: 16];
      ld_ext  = rd_word;
      case (mem_size)
         SZ_HALF: ld_ext = {{16{rd_half[15] & ~mem_unsigned}}, rd_half};
         SZ_BYTE: ld_ext = {{24{rd_byte[7] & ~mem_unsigned}}, rd_byte};
         default: ld_ext = rd_word;
      endcase
   end

   // Array write with per-lane enables; contents survive reset.
   always_ff @(posedge clk) begin
      if (do_store) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   // Registered load result, strobes, sticky error and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         read_data_out <= '0;
         read_valid    <= 1'b0;
         fault         <= 1'b0;
         err_sticky    <= 1'b0;
         load_count    <= '0;
         store_count   <= '0;
      end else begin
         read_valid <= do_load;
         fault      <= req & (~legal | conflict);
         if (req & (~legal | conflict)) err_sticky <= 1'b1;
         if (do_load) begin
            read_data_out <= ld_ext;
            if (load_count != '1) load_count <= load_count + 1'b1;
         end
         if (do_store && store_count != '1) begin
            store_count <= store_count + 1'b1;
         end
      end
   end

endmodule

// File: doc/mem_stage_sized.md
Name: mem_stage_sized

Overview:
- Parametrised successor to the single-word data-memory phase of the MIPS datapath; sits between the EX/MEM and MEM/WB pipeline registers.
- Adds byte/halfword/word loads and stores with sign or zero extension.
- Adds a registered 1-cycle read with a valid strobe, plus misalignment, range and conflict checking, sticky error capture and saturating access counters.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the data array; power of two, minimum 4.
- ADDR_W, 32, width of the byte address input.
- CNT_W, 16, width of the load and store counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- alu_result  in  ADDR_W  byte address
- read_data2  in  32  store data; the low bits are used for sub-word stores
- memwrite  in  1  store request this cycle
- memread  in  1  load request this cycle
- mem_size  in  2  00 word, 01 half, 10 byte, 11 reserved
- mem_unsigned  in  1  load extension: 1 zero-extend, 0 sign-extend
- read_data_out  out  32  extended load result, registered
- read_valid  out  1  one-cycle pulse: read_data_out updated from a legal load
- fault  out  1  one-cycle pulse: the access in the previous cycle was rejected
- err_sticky  out  1  set by any fault; cleared only by rst
- load_count  out  CNT_W  legal loads completed, saturating
- store_count  out  CNT_W  legal stores completed, saturating

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset rst is synchronous and active-high.
- On a rst cycle:
  - read_data_out, read_valid, fault, err_sticky, load_count and store_count all go to 0.
  - Any request presented in that cycle is discarded.
  - Memory array contents are NOT cleared.
- Word index = alu_result[log2(DEPTH_WORDS)+1 : 2]. Byte lane = alu_result[1:0]. Little-endian: lane 0 = bits 7:0.
- An access is legal only if all of the following hold:
  - mem_size is not 11.
  - Halfword: alu_result[0] = 0.
  - Word: alu_result[1:0] = 00.
  - alu_result bits above log2(DEPTH_WORDS)+1 are all zero.
- Store (memwrite=1 and legal):
  - Written at the rising edge of the request cycle.
  - Only the addressed lanes change: byte writes read_data2[7:0]; half writes read_data2[15:0] to lanes {1,0} or {3,2}; word writes all 32 bits.
  - store_count increments.
- Load (memread=1 and legal):
  - The array is sampled at the request edge; the value appears on read_data_out one cycle later, with read_valid = 1 in that cycle.
  - Extension: byte uses bit 7 and half uses bit 15 when mem_unsigned = 0; zero-fill when mem_unsigned = 1.
  - load_count increments.
  - read_data_out holds its value until the next legal load.
- Back-to-back:
  - A store at cycle N followed by a load of the same address at N+1 returns the new data.
  - Consecutive loads give one read_valid pulse per load, with no bubbles.
- Simultaneous memwrite=1 and memread=1 is a conflict:
  - The store proceeds if it is legal; the load is suppressed.
  - fault pulses next cycle and err_sticky sets.
- Illegal access (misaligned, out of range, or size 11):
  - No array write; read_data_out is unchanged and read_valid stays 0.
  - fault = 1 in the following cycle; err_sticky sets.
  - Counters do not change.
- Counters saturate at all-ones; no wrap.
- With memwrite=0 and memread=0, mem_size and alu_result are ignored.

Test Plan:
- Reset, then store word 0xDEADBEEF @0x4; load word @0x4 next cycle -> read_data_out=0xDEADBEEF and read_valid=1 exactly one cycle after the load; store_count=1, load_count=1.
- Store byte 0x80 @0x9 over a word pre-filled with 0x11223344 at 0x8 -> word @0x8 reads 0x11228044. Load byte signed @0x9 -> 0xFFFFFF80; load byte unsigned @0x9 -> 0x00000080.
- Store half 0xABCD @0x12; load half signed @0x12 -> 0xFFFFABCD; load half unsigned -> 0x0000ABCD. Then load word @0x6 -> no read_valid, fault pulse, err_sticky=1, read_data_out keeps 0x0000ABCD.
- With DEPTH_WORDS=1024, load @0x1000 and store @0x1000 -> both fault, counters unchanged, array unchanged (word @0x0 still holds its prior value).
- memwrite=memread=1, word @0x20, data 0x55 -> array @0x20 = 0x55, no read_valid, fault pulses once. Then assert rst mid-stream alongside a load -> all outputs 0, no read_valid next cycle, and the word @0x20 still reads 0x55.
- Force load_count to all-ones with CNT_W=4 (15 loads) and issue one more load -> load_count stays 0xF.
